// File: rtl/gpio_lane_arbiter.sv
// Round-robin arbiter sharing a 32-bit GPIO output image among four byte-lane writers,
// with a programmable hold-off between commits.
module gpio_lane_arbiter #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        CLOCK_50,
   input  logic        KEY0,
   input  logic        clr,
   input  logic [3:0]  req,
   input  logic [7:0]  lane,
   input  logic [31:0] data,
   output logic [3:0]  ack,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_oe,
   output logic        busy,
   output logic [1:0]  owner
);

   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    rr_q, rr_d;
   logic [1:0]    owner_q, owner_d;
   logic [3:0]    ack_q, ack_d;
   logic [31:0]   out_q, out_d;
   logic [31:0]   oe_q, oe_d;

   logic          gnt_valid;
   logic [1:0]    gnt_idx;
   logic [1:0]    gnt_lane;
   logic [1:0]    cand;

   // First asserted requester at or after the RR pointer, searching upward mod 4.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand = rr_q + 2'(i);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
      gnt_lane = lane[2*gnt_idx +: 2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      ack_d   = '0;
      out_d   = out_q;
      oe_d    = oe_q;
      if (clr) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         out_d   = '0;
         oe_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_valid) begin
                  out_d[8*gnt_lane +: 8] = data[8*gnt_idx +: 8];
                  oe_d[8*gnt_lane +: 8]  = '1;
                  ack_d[gnt_idx]         = 1'b1;
                  owner_d                = gnt_idx;
                  rr_d                   = gnt_idx + 2'd1;
                  cnt_d                  = CW'(HOLD_CYCLES - 1);
                  state_d                = S_HOLD;
               end
            end
            default: begin
               if (cnt_q == '0) state_d = S_IDLE;
               else             cnt_d   = cnt_q - CW'(1);
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         owner_q <= '0;
         ack_q   <= '0;
         out_q   <= '0;
         oe_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
      end
   end

   assign ack      = ack_q;
   assign gpio_out = out_q;
   assign gpio_oe  = oe_q;
   assign busy     = (state_q == S_HOLD);
   assign owner    = owner_q;

endmodule

// File: tb/tb_gpio_lane_arbiter.sv
// Directed bench for gpio_lane_arbiter: a per-cycle vector table plus hand-written
// sequences for reset, round-robin spacing and mid-HOLD reset.
module tb_gpio_lane_arbiter;

   logic        CLOCK_50 = 1'b0;
   logic        KEY0;
   logic        clr;
   logic [3:0]  req;
   logic [7:0]  lane;
   logic [31:0] data;
   logic [3:0]  ack;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oe;
   logic        busy;
   logic [1:0]  owner;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc_n  = 0;

   gpio_lane_arbiter #(.HOLD_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50), .KEY0(KEY0), .clr(clr), .req(req), .lane(lane), .data(data),
      .ack(ack), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .busy(busy), .owner(owner)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic        clr;
      logic [3:0]  req;
      logic [7:0]  lane;
      logic [31:0] data;
      logic [3:0]  e_ack;
      logic [31:0] e_out;
      logic [31:0] e_oe;
      logic        e_busy;
      logic [1:0]  e_own;
   } vec_t;

   vec_t vt[20];

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      cyc_n++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic chk_all(input string nm, input logic [3:0] a, input logic [31:0] o,
                          input logic [31:0] e, input logic b, input logic [1:0] w);
      chk({nm, "_ack"},   32'(ack),      32'(a));
      chk({nm, "_out"},   gpio_out,      o);
      chk({nm, "_oe"},    gpio_oe,       e);
      chk({nm, "_busy"},  32'(busy),     32'(b));
      chk({nm, "_owner"}, 32'(owner),    32'(w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel_cyc;
      int last_cyc;
      int waited;
      logic [1:0] rr_exp[5];
      rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      // Reset with all requests pending.
      KEY0 = 1'b0; clr = 1'b0; req = 4'hF; lane = 8'hE4; data = 32'h4433_2211;
      tick(); tick();
      chk_all("reset", 4'h0, 32'h0, 32'h0, 1'b0, 2'd0);

      // Round-robin: each requester drops after its ack; requester 0 re-requests after ack 1.
      KEY0     = 1'b1;
      rel_cyc  = cyc_n;
      last_cyc = cyc_n;
      for (int k = 0; k < 5; k++) begin
         waited = 0;
         do begin
            tick();
            waited++;
         end while (ack == 4'h0 && waited < 20);
         chk($sformatf("rr%0d_ack", k), 32'(ack), 32'(4'b0001 << rr_exp[k]));
         chk($sformatf("rr%0d_owner", k), 32'(owner), 32'(rr_exp[k]));
         if (k == 0) chk("rr0_latency", 32'(cyc_n - rel_cyc), 32'd1);
         else        chk($sformatf("rr%0d_gap", k), 32'(cyc_n - last_cyc), 32'd5);
         last_cyc = cyc_n;
         req[rr_exp[k]] = 1'b0;
         if (k == 1) req[0] = 1'b1;
      end
      chk("rr_image", gpio_out, 32'h4433_2211);
      chk("rr_oe", gpio_oe, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) tick();

      //       clr   req   lane   data            ack   out            oe             busy  owner
      vt[0]  = '{1'b1, 4'h0, 8'h00, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0, 2'd0};
      vt[1]  = '{1'b0, 4'h4, 8'h30, 32'h00A5_0000, 4'h4, 32'hA500_0000, 32'hFF00_0000, 1'b1, 2'd2};
      vt[2]  = '{1'b0, 4'h0, 8'h30, 32'h00A5_0000, 4'h0, 32'hA500_0000, 32'hFF00_0000, 1'b1, 2'd2};
      vt[3]  = '{1'b0, 4'h0, 8'h30, 32'h00A5_0000, 4'h0, 32'hA500_0000, 32'hFF00_0000, 1'b1, 2'd2};
      vt[4]  = '{1'b0, 4'h0, 8'h30, 32'h00A5_0000, 4'h0, 32'hA500_0000, 32'hFF00_0000, 1'b1, 2'd2};
      vt[5]  = '{1'b1, 4'h0, 8'h30, 32'h00A5_0000, 4'h0, 32'h0,         32'h0,         1'b0, 2'd2};
      vt[6]  = '{1'b0, 4'h3, 8'h05, 32'h0000_2211, 4'h1, 32'h0000_1100, 32'h0000_FF00, 1'b1, 2'd0};
      vt[7]  = '{1'b0, 4'h2, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_1100, 32'h0000_FF00, 1'b1, 2'd0};
      vt[8]  = '{1'b0, 4'h2, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_1100, 32'h0000_FF00, 1'b1, 2'd0};
      vt[9]  = '{1'b0, 4'h2, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_1100, 32'h0000_FF00, 1'b1, 2'd0};
      vt[10] = '{1'b0, 4'h2, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_1100, 32'h0000_FF00, 1'b0, 2'd0};
      vt[11] = '{1'b0, 4'h2, 8'h05, 32'h0000_2211, 4'h2, 32'h0000_2200, 32'h0000_FF00, 1'b1, 2'd1};
      vt[12] = '{1'b0, 4'h0, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_2200, 32'h0000_FF00, 1'b1, 2'd1};
      vt[13] = '{1'b0, 4'h0, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_2200, 32'h0000_FF00, 1'b1, 2'd1};
      vt[14] = '{1'b0, 4'h0, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_2200, 32'h0000_FF00, 1'b1, 2'd1};
      vt[15] = '{1'b0, 4'h0, 8'h05, 32'h0000_2211, 4'h0, 32'h0000_2200, 32'h0000_FF00, 1'b0, 2'd1};
      vt[16] = '{1'b1, 4'h8, 8'h80, 32'h5A00_0000, 4'h0, 32'h0,         32'h0,         1'b0, 2'd1};
      vt[17] = '{1'b0, 4'h8, 8'h80, 32'h5A00_0000, 4'h8, 32'h005A_0000, 32'h00FF_0000, 1'b1, 2'd3};
      vt[18] = '{1'b1, 4'h0, 8'h80, 32'h5A00_0000, 4'h0, 32'h0,         32'h0,         1'b0, 2'd3};
      vt[19] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0, 2'd3};

      for (int i = 0; i < 20; i++) begin
         clr = vt[i].clr; req = vt[i].req; lane = vt[i].lane; data = vt[i].data;
         tick();
         chk_all($sformatf("v%0d", i), vt[i].e_ack, vt[i].e_out, vt[i].e_oe,
                 vt[i].e_busy, vt[i].e_own);
      end

      // Mid-HOLD reset: requester 2 stays pending across the reset pulse.
      clr = 1'b0; req = 4'h6; lane = 8'h24; data = 32'h0077_6600;
      tick();
      chk_all("mh_grant", 4'h2, 32'h0000_6600, 32'h0000_FF00, 1'b1, 2'd1);
      req = 4'h4;
      tick();
      chk("mh_hold_busy", 32'(busy), 32'd1);
      #3 KEY0 = 1'b0;
      #1 chk_all("mh_async", 4'h0, 32'h0, 32'h0, 1'b0, 2'd0);
      tick();
      chk_all("mh_in_reset", 4'h0, 32'h0, 32'h0, 1'b0, 2'd0);
      KEY0 = 1'b1;
      tick();
      chk_all("mh_rearb", 4'h4, 32'h0077_0000, 32'h00FF_0000, 1'b1, 2'd2);
      req = 4'h0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_lane_arbiter.md
# gpio_lane_arbiter

Shares the 32-bit DE-series GPIO output header among four internal requesters, each of which writes one 8-bit lane at a time. The block arbitrates round-robin, commits the winning byte into a registered 32-bit output image with per-lane output enables, and acknowledges the winner. It then enforces a programmable hold-off before the next commit, so header pins never change faster than external hardware can follow. It sits between the design's GPIO-producing logic and the top-level `GPIO` inout, which the parent drives from `gpio_out`/`gpio_oe`.

## Interface
- `HOLD_CYCLES`, default 4: minimum cycles spent in HOLD after each commit; legal range 1..255.
- `CLOCK_50`  in  1  DE-series 50 MHz clock; all state on its rising edge.
- `KEY0`  in  1  reset, asynchronous, active-low (board pushbutton KEY[0]).
- `clr`  in  1  synchronous clear of the output image.
- `req`  in  4  request per requester i; held high until `ack[i]`.
- `lane`  in  8  `lane[2i+1:2i]` = target byte lane of requester i (0 → bits 7:0 … 3 → bits 31:24).
- `data`  in  32  `data[8i+7:8i]` = byte from requester i.
- `ack`  out  4  one-hot, one-cycle pulse: requester i's byte has been committed.
- `gpio_out`  out  32  registered output image.
- `gpio_oe`  out  32  per-bit output enable; a byte lane's 8 bits are all 1 once that lane has been written.
- `busy`  out  1  high while in HOLD.
- `owner`  out  2  index of the most recent winner.

## Operation
- Reset (KEY0=0, async): state IDLE, `gpio_out`=0, `gpio_oe`=0 (all pins high-Z), `ack`=0, `busy`=0, `owner`=0, RR pointer=0, hold counter=0.
- States: IDLE, HOLD.
- IDLE, `clr`=0, any `req` high: winner = first asserted requester at or after the RR pointer, searching upward mod 4. On the next edge:
  - write `data` byte of the winner into lane `lane[winner]` of `gpio_out`;
  - set that lane's 8 `gpio_oe` bits; other lanes are unchanged;
  - `ack[winner]`=1, `owner`=winner, RR pointer = (winner+1) mod 4;
  - counter = HOLD_CYCLES-1; go to HOLD.
- IDLE, no `req`: remain in IDLE, no change.
- HOLD: `busy`=1 and `req` is ignored. If counter=0, go to IDLE next edge; otherwise decrement.
- `clr`=1 (any state): next edge `gpio_out`=0, `gpio_oe`=0, state IDLE, `ack`=0, counter=0. `clr` wins over a same-cycle grant; that request is not acked and stays pending. RR pointer and `owner` are preserved.
- Two requesters targeting the same lane are serialized; the later commit overwrites.
- `lane` and `data` are sampled only in the arbitration cycle. Requesters must hold them stable while `req` is high.

## Timing
- Request presented at cycle t in IDLE → `gpio_out`, `gpio_oe`, and `ack` update at edge t+1. Commit latency is 1 cycle.
- `ack` is high during the first HOLD cycle only.
- The next grant is arbitrated no earlier than cycle t+1+HOLD_CYCLES. Commits are spaced ≥ HOLD_CYCLES+1 cycles apart.
- A requester that registers `ack` and clears `req` on the following edge is never double-granted, for any HOLD_CYCLES ≥ 1.
- Reset asserted mid-HOLD clears everything immediately, with no ack. After reset is released, arbitration resumes at the first edge.
- Hold counter width is $clog2(HOLD_CYCLES+1).

## Test plan
- Reset: KEY0 low with `req`=4'hF → `gpio_out`=0, `gpio_oe`=0, `ack`=0, `busy`=0. Release KEY0 → requester 0 is acked at the first edge.
- Single write: HOLD_CYCLES=4, req[2]=1, lane[5:4]=2'd3, data[23:16]=8'hA5 → next edge `gpio_out`=32'hA500_0000, `gpio_oe`=32'hFF00_0000, `ack`=4'b0100, `owner`=2. `busy` high for exactly 4 cycles.
- Round-robin: all four `req` held, each dropped after its ack → ack order 0,1,2,3,0, with consecutive acks exactly 5 cycles apart.
- Lane collision: req0 lane 1 data 8'h11 and req1 lane 1 data 8'h22 asserted together → first commit gives `gpio_out`[15:8]=8'h11, the next gives 8'h22. `gpio_oe`=32'h0000_FF00 throughout.
- Clear priority: `clr`=1 in the same cycle as req[3] in IDLE → no ack, `gpio_out`=0, `gpio_oe`=0. With `clr`=0 on the next cycle, req[3] commits.
- Mid-HOLD reset: KEY0 pulsed low during HOLD → all outputs 0 asynchronously, state IDLE, the pending request is re-arbitrated after release.
